// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding selects,
// MDU sequencer state encoding and the register-compare helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // $0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Multi-cycle mult/div sequencer: IDLE -> BUSY for MDU_LAT cycles -> one-cycle
// DONE, during which HI/LO are written. State is exported for debug and stall logic.
module mdu_sequencer
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output mdu_state_e o_state
);

  localparam logic [3:0] LAT_M1 = 4'(MDU_LAT - 1);

  mdu_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= MDU_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start seen while BUSY is ignored; the pipeline never issues one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MDU_IDLE: begin
        if (i_start) begin
          state_d = MDU_BUSY;
          cnt_d   = LAT_M1;
        end
      end
      MDU_BUSY: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = MDU_DONE;
      end
      MDU_DONE: begin
        if (i_start) begin
          state_d = MDU_BUSY;
          cnt_d   = LAT_M1;
        end else begin
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  assign o_busy  = (state_q == MDU_BUSY);
  assign o_done  = (state_q == MDU_DONE);
  assign o_state = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use, branch and MDU stalls,
// EX/ID forwarding selects and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_rsD,
  input  logic [4:0]       i_rtD,
  input  logic             i_branchD,
  input  logic             i_mdu_useD,
  input  logic [4:0]       i_rsE,
  input  logic [4:0]       i_rtE,
  input  logic [4:0]       i_write_regE,
  input  logic             i_reg_writeE,
  input  logic             i_mem_to_regE,
  input  logic             i_mdu_startE,
  input  logic [4:0]       i_write_regM,
  input  logic             i_reg_writeM,
  input  logic             i_mem_to_regM,
  input  logic [4:0]       i_write_regW,
  input  logic             i_reg_writeW,
  input  logic             i_cnt_clr,
  output logic             o_stallF,
  output logic             o_stallD,
  output logic             o_flushE,
  output logic [1:0]       o_forwardAE,
  output logic [1:0]       o_forwardBE,
  output logic             o_forwardAD,
  output logic             o_forwardBD,
  output logic             o_mdu_busy,
  output logic             o_mdu_done,
  output logic [CNT_W-1:0] o_stall_cnt
);

  mdu_state_e       mdu_state;
  logic             lw_stall, br_stall, mdu_stall, stall;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  mdu_sequencer #(.MDU_LAT(MDU_LAT)) u_mdu_seq (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_mdu_startE),
    .o_busy  (o_mdu_busy),
    .o_done  (o_mdu_done),
    .o_state (mdu_state)
  );

  assign lw_stall = i_mem_to_regE &
                    (reg_match(i_rtE, i_rsD) | reg_match(i_rtE, i_rtD));

  // Branches resolve in ID, so an ALU result still in EX or a load still in MEM must wait.
  assign br_stall = i_branchD &
                    ((i_reg_writeE & (reg_match(i_write_regE, i_rsD) |
                                      reg_match(i_write_regE, i_rtD))) |
                     (i_mem_to_regM & (reg_match(i_write_regM, i_rsD) |
                                       reg_match(i_write_regM, i_rtD))));

  assign mdu_stall = i_mdu_useD & ((mdu_state == MDU_BUSY) | i_mdu_startE);
  assign stall     = lw_stall | br_stall | mdu_stall;

  assign o_stallF = stall;
  assign o_stallD = stall;
  assign o_flushE = stall;

  always_comb begin
    o_forwardAE = FWD_RF;
    o_forwardBE = FWD_RF;
    if (i_reg_writeM && reg_match(i_write_regM, i_rsE))      o_forwardAE = FWD_MEM;
    else if (i_reg_writeW && reg_match(i_write_regW, i_rsE)) o_forwardAE = FWD_WB;
    if (i_reg_writeM && reg_match(i_write_regM, i_rtE))      o_forwardBE = FWD_MEM;
    else if (i_reg_writeW && reg_match(i_write_regW, i_rtE)) o_forwardBE = FWD_WB;
  end

  assign o_forwardAD = i_reg_writeM & reg_match(i_write_regM, i_rsD);
  assign o_forwardBD = i_reg_writeM & reg_match(i_write_regM, i_rtD);

  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr)                    cnt_d = '0;
    else if (stall && (cnt_q != '1))  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: constant vector table, directed multi-cycle sequences
// and random traffic scored against a cycle-count model of the pipeline rules.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic i_clk, i_rst_n;
  logic [4:0] i_rsD, i_rtD, i_rsE, i_rtE, i_write_regE, i_write_regM, i_write_regW;
  logic i_branchD, i_mdu_useD, i_reg_writeE, i_mem_to_regE, i_mdu_startE;
  logic i_reg_writeM, i_mem_to_regM, i_reg_writeW, i_cnt_clr;
  logic o_stallF, o_stallD, o_flushE, o_forwardAD, o_forwardBD, o_mdu_busy, o_mdu_done;
  logic [1:0] o_forwardAE, o_forwardBE;
  logic [CNT_W-1:0] o_stall_cnt;

  hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rsD(i_rsD), .i_rtD(i_rtD), .i_branchD(i_branchD), .i_mdu_useD(i_mdu_useD),
    .i_rsE(i_rsE), .i_rtE(i_rtE), .i_write_regE(i_write_regE),
    .i_reg_writeE(i_reg_writeE), .i_mem_to_regE(i_mem_to_regE), .i_mdu_startE(i_mdu_startE),
    .i_write_regM(i_write_regM), .i_reg_writeM(i_reg_writeM), .i_mem_to_regM(i_mem_to_regM),
    .i_write_regW(i_write_regW), .i_reg_writeW(i_reg_writeW), .i_cnt_clr(i_cnt_clr),
    .o_stallF(o_stallF), .o_stallD(o_stallD), .o_flushE(o_flushE),
    .o_forwardAE(o_forwardAE), .o_forwardBE(o_forwardBE),
    .o_forwardAD(o_forwardAD), .o_forwardBD(o_forwardBD),
    .o_mdu_busy(o_mdu_busy), .o_mdu_done(o_mdu_done), .o_stall_cnt(o_stall_cnt)
  );

  // ---------------- clock ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk)
    if (i_rst_n && i_mdu_startE)
      assert (!o_mdu_busy) else $error("mdu start issued while unit busy");

  // ---------------- reference model ----------------
  typedef struct packed {
    logic stall; logic [1:0] fae; logic [1:0] fbe; logic fad; logic fbd;
    logic busy; logic done; logic [CNT_W-1:0] cnt;
  } out_t;
  localparam int OW = $bits(out_t);

  int errors = 0;
  int checks = 0;
  int m_busy_left;   // remaining BUSY cycles, including the current one
  bit m_done;
  int m_cnt;
  logic [OW-1:0] exp_q[$];

  function automatic bit same(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] r);
    if (i_reg_writeM && same(i_write_regM, r)) return 2'b10;
    if (i_reg_writeW && same(i_write_regW, r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t model_out();
    out_t o;
    bit lw, br, md;
    lw = i_mem_to_regE && (same(i_rtE, i_rsD) || same(i_rtE, i_rtD));
    br = i_branchD &&
         ((i_reg_writeE && (same(i_write_regE, i_rsD) || same(i_write_regE, i_rtD))) ||
          (i_mem_to_regM && (same(i_write_regM, i_rsD) || same(i_write_regM, i_rtD))));
    md = i_mdu_useD && (m_busy_left > 0 || i_mdu_startE);
    o.stall = lw || br || md;
    o.fae   = fwd_sel(i_rsE);
    o.fbe   = fwd_sel(i_rtE);
    o.fad   = i_reg_writeM && same(i_write_regM, i_rsD);
    o.fbd   = i_reg_writeM && same(i_write_regM, i_rtD);
    o.busy  = (m_busy_left > 0);
    o.done  = m_done;
    o.cnt   = m_cnt[CNT_W-1:0];
    return o;
  endfunction

  task automatic model_edge();
    out_t o;
    o = model_out();
    if (i_cnt_clr)    m_cnt = 0;
    else if (o.stall) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
    if (m_busy_left > 0) begin
      m_done      = (m_busy_left == 1);
      m_busy_left = m_busy_left - 1;
    end else begin
      m_done      = 1'b0;
      m_busy_left = i_mdu_startE ? MDU_LAT : 0;
    end
  endtask

  task automatic model_reset();
    m_busy_left = 0;
    m_done      = 1'b0;
    m_cnt       = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven just after a negedge; outputs are checked 1 time unit later.
  task automatic cycle();
    out_t e;
    #1;
    exp_q.push_back(model_out());
    e = out_t'(exp_q.pop_front());
    check("stallF",   32'(o_stallF),    32'(e.stall));
    check("stallD",   32'(o_stallD),    32'(e.stall));
    check("flushE",   32'(o_flushE),    32'(e.stall));
    check("fwdAE",    32'(o_forwardAE), 32'(e.fae));
    check("fwdBE",    32'(o_forwardBE), 32'(e.fbe));
    check("fwdAD",    32'(o_forwardAD), 32'(e.fad));
    check("fwdBD",    32'(o_forwardBD), 32'(e.fbd));
    check("mdu_busy", 32'(o_mdu_busy),  32'(e.busy));
    check("mdu_done", 32'(o_mdu_done),  32'(e.done));
    check("stall_cnt",32'(o_stall_cnt), 32'(e.cnt));
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
  endtask

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    {i_rsD, i_rtD, i_rsE, i_rtE, i_write_regE, i_write_regM, i_write_regW} = '0;
    {i_branchD, i_mdu_useD, i_reg_writeE, i_mem_to_regE, i_mdu_startE} = '0;
    {i_reg_writeM, i_mem_to_regM, i_reg_writeW, i_cnt_clr} = '0;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    check({name, "_stallF"}, 32'(o_stallF), 32'(exp));
    check({name, "_stallD"}, 32'(o_stallD), 32'(exp));
    check({name, "_flushE"}, 32'(o_flushE), 32'(exp));
  endtask

  typedef struct {
    logic [4:0] rsD, rtD; logic br;
    logic [4:0] rsE, rtE, wrE; logic rwE, mtrE;
    logic [4:0] wrM; logic rwM, mtrM;
    logic [4:0] wrW; logic rwW;
    logic stall; logic [1:0] fae, fbe; logic fad, fbd;
  } vec_t;
  vec_t vecs[12];

  initial begin
    //            rsD rtD br rsE rtE wrE rwE mtrE wrM rwM mtrM wrW rwW stl fae    fbe    fad fbd
    vecs[0]  = '{1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
    vecs[1]  = '{0, 0, 0, 3, 7, 0, 0, 0, 3, 1, 0, 3, 1, 0, 2'b10, 2'b00, 0, 0};
    vecs[2]  = '{0, 0, 0, 3, 6, 0, 0, 0, 3, 0, 0, 6, 1, 0, 2'b00, 2'b01, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0};
    vecs[4]  = '{5, 1, 0, 0, 5, 5, 1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0};
    vecs[5]  = '{2, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
    vecs[7]  = '{4, 9, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0};
    vecs[8]  = '{4, 9, 1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0};
    vecs[9]  = '{1, 4, 1, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1};
    vecs[10] = '{4, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
    vecs[11] = '{0, 0, 0, 8, 8, 0, 0, 0, 8, 1, 0, 8, 1, 0, 2'b10, 2'b10, 0, 0};
  end

  // ---------------- test ----------------
  initial begin
    string nm;
    clear_inputs();
    model_reset();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_busy", 32'(o_mdu_busy),  32'd0);
    check("reset_done", 32'(o_mdu_done),  32'd0);
    check("reset_cnt",  32'(o_stall_cnt), 32'd0);
    i_rst_n = 1'b1;

    // Table of single-cycle hazard/forward patterns
    foreach (vecs[i]) begin
      clear_inputs();
      {i_rsD, i_rtD, i_branchD} = {vecs[i].rsD, vecs[i].rtD, vecs[i].br};
      {i_rsE, i_rtE, i_write_regE} = {vecs[i].rsE, vecs[i].rtE, vecs[i].wrE};
      {i_reg_writeE, i_mem_to_regE} = {vecs[i].rwE, vecs[i].mtrE};
      {i_write_regM, i_reg_writeM, i_mem_to_regM} = {vecs[i].wrM, vecs[i].rwM, vecs[i].mtrM};
      {i_write_regW, i_reg_writeW} = {vecs[i].wrW, vecs[i].rwW};
      #1;
      nm = $sformatf("vec%0d", i);
      chk_stall(nm, vecs[i].stall);
      check({nm, "_fAE"}, 32'(o_forwardAE), 32'(vecs[i].fae));
      check({nm, "_fBE"}, 32'(o_forwardBE), 32'(vecs[i].fbe));
      check({nm, "_fAD"}, 32'(o_forwardAD), 32'(vecs[i].fad));
      check({nm, "_fBD"}, 32'(o_forwardBD), 32'(vecs[i].fbd));
      cycle();
    end

    // Load-use: one stall cycle, then the load has moved to MEM
    clear_inputs();
    i_mem_to_regE = 1; i_reg_writeE = 1; i_rtE = 5; i_write_regE = 5; i_rsD = 5;
    #1 chk_stall("lw_t0", 1'b1);
    cycle();
    clear_inputs();
    i_write_regM = 5; i_reg_writeM = 1; i_mem_to_regM = 1; i_rsD = 5;
    #1 chk_stall("lw_t1", 1'b0);
    cycle();

    // Branch on an ALU result: stall in EX, forward from MEM next cycle
    clear_inputs();
    i_branchD = 1; i_rsD = 4; i_rtD = 2; i_write_regE = 4; i_reg_writeE = 1;
    #1 chk_stall("br_t0", 1'b1);
    cycle();
    clear_inputs();
    i_branchD = 1; i_rsD = 4; i_rtD = 2; i_write_regM = 4; i_reg_writeM = 1;
    #1 chk_stall("br_t1", 1'b0);
    check("br_t1_fAD", 32'(o_forwardAD), 32'd1);
    cycle();

    // MDU: start at t0, busy t1..t4, done t5; HI/LO user stalls t0..t4
    clear_inputs();
    i_mdu_startE = 1; i_mdu_useD = 1;
    #1 chk_stall("mdu_t0", 1'b1);
    check("mdu_t0_busy", 32'(o_mdu_busy), 32'd0);
    cycle();
    i_mdu_startE = 0;
    for (int k = 1; k <= MDU_LAT; k++) begin
      #1;
      nm = $sformatf("mdu_t%0d", k);
      chk_stall(nm, 1'b1);
      check({nm, "_busy"}, 32'(o_mdu_busy), 32'd1);
      check({nm, "_done"}, 32'(o_mdu_done), 32'd0);
      cycle();
    end
    #1 chk_stall("mdu_t5", 1'b0);
    check("mdu_t5_busy", 32'(o_mdu_busy), 32'd0);
    check("mdu_t5_done", 32'(o_mdu_done), 32'd1);
    cycle();
    i_mdu_useD = 0;
    #1 check("mdu_t6_done", 32'(o_mdu_done), 32'd0);
    cycle();

    // Reset in the second BUSY cycle: immediate IDLE, no done pulse afterwards
    clear_inputs();
    i_mdu_startE = 1;
    cycle();
    i_mdu_startE = 0;
    cycle();
    check("rstmid_busy_before", 32'(o_mdu_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(o_mdu_busy),  32'd0);
    check("rstmid_done", 32'(o_mdu_done),  32'd0);
    check("rstmid_cnt",  32'(o_stall_cnt), 32'd0);
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 check($sformatf("rstmid_nodone%0d", k), 32'(o_mdu_done), 32'd0);
      cycle();
    end

    // Saturating counter: 20 stalled cycles, then clear wins over increment
    clear_inputs();
    i_mem_to_regE = 1; i_rtE = 7; i_rsD = 7;
    repeat (20) cycle();
    #1 check("sat_cnt", 32'(o_stall_cnt), 32'(CNT_MAX));
    i_cnt_clr = 1;
    cycle();
    i_cnt_clr = 0;
    clear_inputs();
    #1 check("clr_cnt", 32'(o_stall_cnt), 32'd0);
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      i_rsD = 5'($urandom_range(0, 3));  i_rtD = 5'($urandom_range(0, 3));
      i_rsE = 5'($urandom_range(0, 3));  i_rtE = 5'($urandom_range(0, 3));
      i_write_regE = 5'($urandom_range(0, 3));
      i_write_regM = 5'($urandom_range(0, 3));
      i_write_regW = 5'($urandom_range(0, 3));
      i_branchD     = ($urandom_range(0, 3) == 0);
      i_mdu_useD    = ($urandom_range(0, 2) == 0);
      i_reg_writeE  = $urandom_range(0, 1) != 0;
      i_mem_to_regE = ($urandom_range(0, 3) == 0);
      i_reg_writeM  = $urandom_range(0, 1) != 0;
      i_mem_to_regM = ($urandom_range(0, 3) == 0);
      i_reg_writeW  = $urandom_range(0, 1) != 0;
      i_cnt_clr     = ($urandom_range(0, 15) == 0);
      i_mdu_startE  = (m_busy_left == 0) && ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
